pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Merges three inputs into one coherent set of per-stage write-enable, flush and bubble controls:
  - the load-use request from the hazard detection unit,
  - the taken-branch flush from ID,
  - multi-cycle data-memory waits from MEM.
- Owns the run/halt sequencing after start_i, plus a memory-wait watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_wait_wdog.sv | 47 ++++
 rtl/pipe_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encoding,
// default watchdog limit and the per-stage control bundle with its RUN decode.
package pipe_ctrl_pkg;

  localparam int WAIT_MAX_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_we;
    logic mem_wb_we;
    logic mem_wb_bubble;
  } ctrl_t;

  // Load-use wins over a taken branch: the branch resolved on stale operands.
  function automatic ctrl_t run_decode(input logic load_use, input logic branch_taken);
    ctrl_t c;
    c = '0;
    c.ex_mem_we = 1'b1;
    c.mem_wb_we = 1'b1;
    if (load_use) begin
      c.id_ex_bubble = 1'b1;
    end else begin
      c.pc_we       = 1'b1;
      c.if_id_we    = 1'b1;
      c.if_id_flush = branch_taken;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_wait_wdog.sv
// Memory-wait watchdog: counts consecutive wait cycles and latches a sticky
// error once the count reaches WAIT_MAX. clr together with inc loads 1.
module pipe_wait_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic trip_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;
  assign trip_o  = inc_i & ~clr_i & (cnt_inc >= LIMIT);
  assign err_o   = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | trip_o;
    if (clr_i) begin
      cnt_d = {{(CNT_W-1){1'b0}}, inc_i};
    end else if (inc_i) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Optional performance
// counters (stall_cnt_o, flush_cnt_o) are built when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF,
  parameter int CNT_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic load_use_i,
  input  logic branch_taken_i,
  input  logic dmem_req_i,
  input  logic dmem_ack_i,
  output logic pc_we_o,
  output logic if_id_we_o,
  output logic if_id_flush_o,
  output logic id_ex_bubble_o,
  output logic ex_mem_we_o,
  output logic mem_wb_we_o,
  output logic mem_wb_bubble_o,
  output logic wd_err_o
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   mem_stall;
  logic   wd_clr, wd_inc, wd_trip, wd_err;

  assign mem_stall = dmem_req_i & ~dmem_ack_i;

  // In MEM_WAIT the pending request is implied, so only the ack matters.
  assign wd_inc = ((state_q == ST_RUN) & mem_stall) | ((state_q == ST_MEM_WAIT) & ~dmem_ack_i);
  assign wd_clr = ((state_q == ST_RUN) & mem_stall) | ((state_q == ST_MEM_WAIT) & dmem_ack_i);

  pipe_wait_wdog #(
    .WAIT_MAX (WAIT_MAX),
    .CNT_W    (CNT_W)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (wd_clr),
    .inc_i  (wd_inc),
    .trip_o (wd_trip),
    .err_o  (wd_err)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (mem_stall) begin
          ctrl.mem_wb_bubble = 1'b1;
          state_d            = ST_MEM_WAIT;
        end else begin
          ctrl    = run_decode(load_use_i, branch_taken_i);
          state_d = start_i ? ST_RUN : ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ack_i) begin
          ctrl.mem_wb_bubble = 1'b1;
          if (wd_trip) state_d = ST_HALT;
        end else begin
          ctrl    = run_decode(load_use_i, branch_taken_i);
          state_d = start_i ? ST_RUN : ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rst_i) begin
      ctrl    = '0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_we_o         = ctrl.pc_we;
  assign if_id_we_o      = ctrl.if_id_we;
  assign if_id_flush_o   = ctrl.if_id_flush;
  assign id_ex_bubble_o  = ctrl.id_ex_bubble;
  assign ex_mem_we_o     = ctrl.ex_mem_we;
  assign mem_wb_we_o     = ctrl.mem_wb_we;
  assign mem_wb_bubble_o = ctrl.mem_wb_bubble;
  assign wd_err_o        = wd_err & ~rst_i;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        stall_cyc;

  // A stall cycle is any active-pipeline cycle in which the PC is held.
  assign stall_cyc = ((state_q == ST_RUN) | (state_q == ST_MEM_WAIT)) & ~ctrl.pc_we;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_cyc};
    flush_cnt_d = flush_cnt_q + {31'd0, ctrl.if_id_flush};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, watchdog/perf sequences and
// randomized traffic checked against a cycle-counting reference model.
module tb_pipe_stall_ctrl;

  localparam int WM = 4;

  logic clk = 1'b0;
  logic rst, start, lu, br, req, ack;
  logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, mem_wb_bubble, wd_err;
`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_stall_ctrl #(
    .WAIT_MAX (WM),
    .CNT_W    (8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .load_use_i      (lu),
    .branch_taken_i  (br),
    .dmem_req_i      (req),
    .dmem_ack_i      (ack),
    .pc_we_o         (pc_we),
    .if_id_we_o      (if_id_we),
    .if_id_flush_o   (if_id_flush),
    .id_ex_bubble_o  (id_ex_bubble),
    .ex_mem_we_o     (ex_mem_we),
    .mem_wb_we_o     (mem_wb_we),
    .mem_wb_bubble_o (mem_wb_bubble),
    .wd_err_o        (wd_err)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Output vector: {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, mem_wb_bubble, wd_err}
  localparam logic [7:0] O_ZERO = 8'h00;
  localparam logic [7:0] O_RUN  = 8'hCC;
  localparam logic [7:0] O_LU   = 8'h1C;
  localparam logic [7:0] O_BR   = 8'hEC;
  localparam logic [7:0] O_FRZ  = 8'h02;
  localparam logic [7:0] O_HALT = 8'h01;

  // Reference model: pipeline running flag, length of the current memory wait,
  // halted flag, sticky error and event tallies.
  bit          m_run, m_halt, m_err;
  int          m_wait;
  int unsigned m_stall, m_flush;

  function automatic logic [7:0] run_out(input logic l, input logic b);
    if (l) return O_LU;
    if (b) return O_BR;
    return O_RUN;
  endfunction

  task automatic model(input logic r, s, l, b, q, a, output logic [7:0] e);
    bit frz;
    e = {7'd0, m_err};
    if (r) begin
      e = O_ZERO;
      m_run = 0; m_halt = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else if (m_halt) begin
      // sits with the error flag showing
    end else if (!m_run) begin
      m_run = s;
    end else begin
      frz = (m_wait > 0) ? !a : (q && !a);
      if (frz) begin
        e = O_FRZ;
        m_wait++;
        m_stall++;
        if (m_wait >= WM) begin
          m_halt = 1;
          m_err  = 1;
        end
      end else begin
        e = run_out(l, b);
        if (!e[7]) m_stall++;
        if (e[5]) m_flush++;
        m_wait = 0;
        m_run  = s;
      end
    end
  endtask

  task automatic step(input logic r, s, l, b, q, a, input logic [7:0] texp, input bit use_t,
                      input string nm);
    logic [7:0] e, act;
    rst = r; start = s; lu = l; br = b; req = q; ack = a;
    @(negedge clk);
`ifdef PIPE_STALL_PERF_EN
    n_vec++;
    if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
      n_err++;
      $display("FAIL %s perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               nm, stall_cnt, flush_cnt, m_stall, m_flush);
    end
`endif
    model(r, s, l, b, q, a, e);
    if (use_t) e = texp;
    act = {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, mem_wb_we, mem_wb_bubble, wd_err};
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %b want %b (in rst=%b st=%b lu=%b br=%b req=%b ack=%b)",
               nm, act, e, r, s, l, b, q, a);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, start, lu, br, req, ack;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 0, O_ZERO, "reset"};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, O_ZERO, "idle_start"};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, O_RUN,  "run_normal"};
    tbl[3]  = '{0, 1, 1, 0, 0, 0, O_LU,   "load_use"};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, O_RUN,  "after_lu"};
    tbl[5]  = '{0, 1, 1, 1, 0, 0, O_LU,   "lu_and_branch"};
    tbl[6]  = '{0, 1, 0, 1, 0, 0, O_BR,   "branch_flush"};
    tbl[7]  = '{0, 1, 0, 0, 1, 1, O_RUN,  "dmem_hit"};
    tbl[8]  = '{0, 1, 0, 0, 0, 1, O_RUN,  "stray_ack"};
    tbl[9]  = '{0, 1, 0, 0, 1, 0, O_FRZ,  "wait1"};
    tbl[10] = '{0, 1, 0, 0, 1, 0, O_FRZ,  "wait2"};
    tbl[11] = '{0, 1, 0, 0, 1, 0, O_FRZ,  "wait3"};
    tbl[12] = '{0, 1, 0, 1, 1, 1, O_BR,   "ack_branch"};
    tbl[13] = '{0, 1, 0, 0, 0, 0, O_RUN,  "post_ack"};
    tbl[14] = '{0, 1, 0, 0, 1, 0, O_FRZ,  "wait_again"};
    tbl[15] = '{1, 1, 0, 0, 1, 0, O_ZERO, "rst_mid_wait"};
    tbl[16] = '{0, 0, 0, 0, 0, 0, O_ZERO, "idle_after_rst"};
    tbl[17] = '{0, 1, 0, 0, 0, 0, O_ZERO, "idle_start2"};
    tbl[18] = '{0, 0, 0, 0, 0, 0, O_RUN,  "run_stop"};
    tbl[19] = '{0, 0, 0, 0, 0, 0, O_ZERO, "idle_stopped"};

    m_run = 0; m_halt = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    rst = 1; start = 0; lu = 0; br = 0; req = 0; ack = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++)
      step(tbl[i].rst, tbl[i].start, tbl[i].lu, tbl[i].br, tbl[i].req, tbl[i].ack,
           tbl[i].exp, 1'b1, tbl[i].nm);

    // Watchdog: four freeze cycles with no ack, then HALT until reset.
    step(1, 0, 0, 0, 0, 0, O_ZERO, 1'b1, "wd_rst");
    step(0, 1, 0, 0, 0, 0, O_ZERO, 1'b1, "wd_idle");
    step(0, 1, 0, 0, 1, 0, O_FRZ,  1'b1, "wd_w1");
    step(0, 1, 0, 0, 1, 0, O_FRZ,  1'b1, "wd_w2");
    step(0, 1, 0, 0, 1, 0, O_FRZ,  1'b1, "wd_w3");
    step(0, 1, 0, 0, 1, 0, O_FRZ,  1'b1, "wd_w4");
    step(0, 1, 0, 1, 1, 1, O_HALT, 1'b1, "wd_halt_a");
    step(0, 1, 1, 0, 0, 0, O_HALT, 1'b1, "wd_halt_b");
    step(0, 1, 0, 0, 0, 0, O_HALT, 1'b1, "wd_halt_c");
    step(1, 1, 0, 0, 0, 0, O_ZERO, 1'b1, "wd_clear");
    step(0, 0, 0, 0, 0, 0, O_ZERO, 1'b1, "wd_after");

`ifdef PIPE_STALL_PERF_EN
    step(1, 0, 0, 0, 0, 0, O_ZERO, 1'b1, "perf_rst");
    step(0, 1, 0, 0, 0, 0, O_ZERO, 1'b1, "perf_idle");
    step(0, 1, 0, 0, 0, 0, O_RUN,  1'b1, "perf_run");
    step(0, 1, 0, 0, 1, 0, O_FRZ,  1'b1, "perf_w1");
    step(0, 1, 0, 0, 1, 0, O_FRZ,  1'b1, "perf_w2");
    step(0, 1, 0, 0, 1, 0, O_FRZ,  1'b1, "perf_w3");
    step(0, 1, 0, 0, 1, 1, O_RUN,  1'b1, "perf_ack");
    #3;
    n_vec++;
    if (stall_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL perf_stall3: got %0d want 3", stall_cnt);
    end
    step(0, 1, 0, 1, 0, 0, O_BR,   1'b1, "perf_br");
    #3;
    n_vec++;
    if (flush_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL perf_flush1: got %0d want 1", flush_cnt);
    end
`endif

    // Randomized traffic against the reference model.
    step(1, 0, 0, 0, 0, 0, O_ZERO, 1'b0, "rnd_rst");
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(31) == 0), ($urandom_range(15) != 0), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0), ($urandom_range(2) == 0), $urandom_range(1) == 1,
           O_ZERO, 1'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
